// File: rtl/tcam_lookup_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tcam_lookup_ctrl : request/response sequencer for a ternary CAM with a   |
// |                    per-entry valid bitmap and saturating hit/miss stats. |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module tcam_lookup_ctrl #(
  parameter int KEY_W  = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [KEY_W-1:0]       req_key,
  input  logic [KEY_W-1:0]       req_mask,
  input  logic [ADDR_W-1:0]      req_addr,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_hit,
  output logic [ADDR_W-1:0]      rsp_addr,
  output logic [KEY_W-1:0]       tcam_data,
  output logic [KEY_W-1:0]       tcam_dontcare_mask,
  output logic [ADDR_W-1:0]      tcam_write_address,
  output logic                   tcam_write_readN,
  input  logic [ADDR_W-1:0]      tcam_found_address,
  input  logic                   tcam_hit,
  output logic [2**ADDR_W-1:0]   entry_valid,
  output logic [CNT_W-1:0]       hit_count,
  output logic [CNT_W-1:0]       miss_count
);

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_INV   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   req_ready_q, req_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_hit_q, rsp_hit_d;
  logic [ADDR_W-1:0]      rsp_addr_q, rsp_addr_d;
  logic [KEY_W-1:0]       data_q, data_d;
  logic [KEY_W-1:0]       mask_q, mask_d;
  logic [ADDR_W-1:0]      waddr_q, waddr_d;
  logic                   wr_q, wr_d;
  logic [2**ADDR_W-1:0]   valid_q, valid_d;
  logic [CNT_W-1:0]       hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]       miss_cnt_q, miss_cnt_d;
  logic                   search_hit;

  // A raw TCAM hit on an entry we never wrote (or invalidated) counts as a miss.
  assign search_hit = tcam_hit & valid_q[tcam_found_address];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    rsp_hit_d  = rsp_hit_q;
    rsp_addr_d = rsp_addr_q;
    data_d     = data_q;
    mask_d     = mask_q;
    waddr_d    = waddr_q;
    valid_d    = valid_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d   = req_op;
          addr_d = req_addr;
          if (req_op == OP_WRITE || req_op == OP_INV) begin
            state_d = S_WRITE;
            waddr_d = req_addr;
            data_d  = (req_op == OP_WRITE) ? req_key  : '0;
            mask_d  = (req_op == OP_WRITE) ? req_mask : '0;
          end else begin
            state_d = S_LOOKUP;
            data_d  = req_key;
          end
        end
      end
      S_LOOKUP: state_d = S_CAPTURE;
      S_CAPTURE: begin
        state_d    = S_RESP;
        rsp_hit_d  = search_hit;
        rsp_addr_d = tcam_hit ? tcam_found_address : '0;
        if (search_hit) begin
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end else begin
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
      end
      S_WRITE: begin
        state_d         = S_RESP;
        rsp_hit_d       = 1'b0;
        rsp_addr_d      = addr_q;
        valid_d[addr_q] = (op_q == OP_WRITE);
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake and strobe outputs are registered so they align with the state entered.
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    wr_d        = (state_d == S_WRITE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_addr_q  <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      waddr_q     <= '0;
      wr_q        <= 1'b0;
      valid_q     <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_addr_q  <= rsp_addr_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      waddr_q     <= waddr_d;
      wr_q        <= wr_d;
      valid_q     <= valid_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign req_ready          = req_ready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_hit            = rsp_hit_q;
  assign rsp_addr           = rsp_addr_q;
  assign tcam_data          = data_q;
  assign tcam_dontcare_mask = mask_q;
  assign tcam_write_address = waddr_q;
  assign tcam_write_readN   = wr_q;
  assign entry_valid        = valid_q;
  assign hit_count          = hit_cnt_q;
  assign miss_count         = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tcam_lookup_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tcam_lookup_ctrl : scoreboard bench with a TCAM stand-in and a        |
// |                       reference model of entries, bitmap and counters.   |
// | Revision            : 1.0                                                |
// +--------------------------------------------------------------------------+
module tb_tcam_lookup_ctrl;

  localparam int KEY_W  = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 8;
  localparam int N      = 16;

  logic              clk = 1'b0;
  logic              resetN = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_op = '0;
  logic [KEY_W-1:0]  req_key = '0;
  logic [KEY_W-1:0]  req_mask = '0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic              rsp_hit;
  logic [ADDR_W-1:0] rsp_addr;
  logic [KEY_W-1:0]  tcam_data;
  logic [KEY_W-1:0]  tcam_dontcare_mask;
  logic [ADDR_W-1:0] tcam_write_address;
  logic              tcam_write_readN;
  logic [ADDR_W-1:0] tcam_found_address;
  logic              tcam_hit;
  logic [N-1:0]      entry_valid;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  tcam_lookup_ctrl #(.KEY_W(KEY_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetN(resetN),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_mask(req_mask), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_addr(rsp_addr),
    .tcam_data(tcam_data), .tcam_dontcare_mask(tcam_dontcare_mask),
    .tcam_write_address(tcam_write_address), .tcam_write_readN(tcam_write_readN),
    .tcam_found_address(tcam_found_address), .tcam_hit(tcam_hit),
    .entry_valid(entry_valid), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // TCAM stand-in: write commits on the strobe edge, search result registered one edge later.
  logic [KEY_W-1:0] t_key [N];
  logic [KEY_W-1:0] t_msk [N];

  function automatic logic [ADDR_W:0] tcam_match(input logic [KEY_W-1:0] d);
    for (int i = 0; i < N; i++)
      if (((d ^ t_key[i]) & ~t_msk[i]) == '0) return {1'b1, ADDR_W'(i)};
    return '0;
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < N; i++) begin
        t_key[i] <= '0;
        t_msk[i] <= '0;
      end
      tcam_hit           <= 1'b0;
      tcam_found_address <= '0;
    end else if (tcam_write_readN) begin
      t_key[tcam_write_address] <= tcam_data;
      t_msk[tcam_write_address] <= tcam_dontcare_mask;
    end else begin
      {tcam_hit, tcam_found_address} <= tcam_match(tcam_data);
    end
  end

  // Reference model and scoreboard.
  typedef struct {
    logic [1:0]        op;
    logic              hit;
    logic [ADDR_W-1:0] addr;
    logic [KEY_W-1:0]  wkey;
    logic [KEY_W-1:0]  wmask;
    logic [N-1:0]      ev;
    logic [CNT_W-1:0]  hc;
    logic [CNT_W-1:0]  mc;
    int unsigned       acc;
  } exp_t;

  exp_t             q[$];
  logic [KEY_W-1:0] ref_key [N];
  logic [KEY_W-1:0] ref_msk [N];
  logic [N-1:0]     ref_valid = '0;
  int unsigned      ref_hc = 0;
  int unsigned      ref_mc = 0;
  int               n_vec = 0;
  int               n_err = 0;
  logic             stall = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < N; i++) begin
      ref_key[i] = '0;
      ref_msk[i] = '0;
    end
    ref_valid = '0;
    ref_hc    = 0;
    ref_mc    = 0;
    q.delete();
  endtask

  task automatic issue(input logic [1:0] op, input logic [KEY_W-1:0] key,
                       input logic [KEY_W-1:0] mask, input logic [ADDR_W-1:0] addr);
    exp_t e;
    int   n;
    int   idx;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_key = key; req_mask = mask; req_addr = addr;
    n = 0;
    @(negedge clk);
    while (!req_ready) begin
      n++;
      if (n > 200) begin
        n_vec++; n_err++;
        $display("FAIL req_timeout: req_ready stayed 0 for %0d cycles, expected 1", n);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    e.op  = op;
    e.acc = cyc + 1;
    e.wkey = '0; e.wmask = '0;
    if (op == 2'b01 || op == 2'b10) begin
      e.hit   = 1'b0;
      e.addr  = addr;
      e.wkey  = (op == 2'b01) ? key  : '0;
      e.wmask = (op == 2'b01) ? mask : '0;
      ref_key[addr]   = e.wkey;
      ref_msk[addr]   = e.wmask;
      ref_valid[addr] = (op == 2'b01);
    end else begin
      idx = -1;
      for (int i = 0; i < N; i++)
        if (idx < 0 && ((key ^ ref_key[i]) & ~ref_msk[i]) == '0) idx = i;
      e.hit  = (idx >= 0) && ref_valid[idx];
      e.addr = (idx >= 0) ? ADDR_W'(idx) : '0;
      if (e.hit) ref_hc = (ref_hc < (1 << CNT_W) - 1) ? ref_hc + 1 : ref_hc;
      else       ref_mc = (ref_mc < (1 << CNT_W) - 1) ? ref_mc + 1 : ref_mc;
    end
    e.ev = ref_valid;
    e.hc = CNT_W'(ref_hc);
    e.mc = CNT_W'(ref_mc);
    q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  always begin
    @(posedge clk); #1;
    rsp_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: checks write strobes and every cycle a response is presented.
  exp_t mon_e;
  logic prev_valid = 1'b0;
  int   wr_pulses = 0;
  always @(negedge clk) begin
    if (!resetN) begin
      prev_valid = 1'b0;
      wr_pulses  = 0;
    end else begin
      if (tcam_write_readN) begin
        wr_pulses++;
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL wr_strobe: got strobe with no request, expected none");
        end else begin
          chk("tcam_write_address", 64'(tcam_write_address), 64'(q[0].addr));
          chk("tcam_data_wr", 64'(tcam_data), 64'(q[0].wkey));
          chk("tcam_mask_wr", 64'(tcam_dontcare_mask), 64'(q[0].wmask));
        end
      end
      if (rsp_valid) begin
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_rsp: got rsp_valid=1 with nothing outstanding, expected 0");
        end else begin
          mon_e = q[0];
          chk("rsp_hit", 64'(rsp_hit), 64'(mon_e.hit));
          chk("rsp_addr", 64'(rsp_addr), 64'(mon_e.addr));
          chk("entry_valid", 64'(entry_valid), 64'(mon_e.ev));
          chk("hit_count", 64'(hit_count), 64'(mon_e.hc));
          chk("miss_count", 64'(miss_count), 64'(mon_e.mc));
          chk("req_ready_in_rsp", 64'(req_ready), 64'd0);
          chk("wr_strobe_in_rsp", 64'(tcam_write_readN), 64'd0);
          if (!prev_valid) begin
            chk("latency", 64'(cyc - mon_e.acc),
                (mon_e.op == 2'b01 || mon_e.op == 2'b10) ? 64'd1 : 64'd2);
            chk("wr_pulses", 64'(wr_pulses),
                (mon_e.op == 2'b01 || mon_e.op == 2'b10) ? 64'd1 : 64'd0);
          end
          if (rsp_ready) begin
            void'(q.pop_front());
            wr_pulses = 0;
          end
        end
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp"}, 64'({rsp_valid, rsp_hit, rsp_addr}), 64'd0);
    chk({tag, "_tcam_pins"}, 64'({tcam_data, tcam_dontcare_mask, tcam_write_address, tcam_write_readN}), 64'd0);
    chk({tag, "_entry_valid"}, 64'(entry_valid), 64'd0);
    chk({tag, "_counters"}, 64'({hit_count, miss_count}), 64'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
    chk("drain_outstanding", 64'(q.size()), 64'd0);
  endtask

  logic [KEY_W-1:0] pool [4];

  initial begin
    ref_reset();
    pool[0] = 16'h0000; pool[1] = 16'h5555; pool[2] = 16'hABCD; pool[3] = 16'hF0F0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    #1 chk("req_ready_before_edge", 64'(req_ready), 64'd0);
    @(posedge clk); #1 chk("req_ready_after_edge", 64'(req_ready), 64'd1);

    issue(2'b00, 16'h1234, '0, '0);
    issue(2'b01, 16'hAB00, 16'h00FF, 4'd5);
    issue(2'b00, 16'hABCD, '0, '0);
    issue(2'b01, 16'h5555, 16'h0000, 4'd3);
    issue(2'b01, 16'h5555, 16'h0000, 4'd9);
    issue(2'b00, 16'h5555, '0, '0);
    issue(2'b10, '0, '0, 4'd3);
    issue(2'b00, 16'h5555, '0, '0);
    issue(2'b11, 16'h0000, '0, '0);
    drain();

    // Back-pressure: response must hold for 10 cycles with nothing else accepted.
    stall = 1'b1;
    issue(2'b00, 16'hABFF, '0, '0);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
    repeat (10) @(negedge clk);
    stall = 1'b0;
    drain();

    // Saturation of both counters.
    issue(2'b01, 16'hC3C3, 16'h0000, 4'd7);
    for (int i = 0; i < 260; i++) issue(2'b00, 16'hC3C3, '0, '0);
    for (int i = 0; i < 260; i++) issue(2'b00, 16'h0001, '0, '0);
    drain();

    for (int i = 0; i < 300; i++) begin
      logic [KEY_W-1:0] k;
      logic [KEY_W-1:0] m;
      k = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) k = k ^ KEY_W'($urandom_range(0, 255));
      m = ($urandom_range(0, 1) == 0) ? '0 : KEY_W'($urandom_range(0, 255));
      issue(2'($urandom_range(0, 3)), k, m, ADDR_W'($urandom_range(0, N - 1)));
    end
    drain();

    // Asynchronous reset while a search is in LOOKUP.
    issue(2'b01, 16'h7777, 16'h0000, 4'd2);
    issue(2'b00, 16'h7777, '0, '0);
    #2 resetN = 1'b0;
    #1 check_all_zero("midop_reset");
    ref_reset();
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    issue(2'b00, 16'h7777, '0, '0);
    issue(2'b01, 16'h7777, 16'h0000, 4'd2);
    issue(2'b00, 16'h7777, '0, '0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
